// File: rtl/trap_sequencer.sv
// Trap / MRET sequencer: takes the oldest exception or MRET, writes the machine trap CSRs
// one at a time over a ready/valid port, then redirects the PC and masks detection for a cycle.
module trap_sequencer #(
    // Width selector: 2'd1 = 32-bit, 2'd2 = 64-bit
    parameter logic [1:0] XLEN = 2'd2,
    localparam int unsigned W = 1 << (XLEN + 4)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [3:0]    i_exc_code_f,
    input  logic [3:0]    i_exc_code_e,
    input  logic [W-1:0]  i_pc_f,
    input  logic [W-1:0]  i_pc_e,
    input  logic [31:0]   i_instr_f,
    input  logic [W-1:0]  i_alu_out_e,
    input  logic          i_mret_e,
    input  logic          i_older_valid_de,
    input  logic [W-1:0]  i_mtvec,
    input  logic [W-1:0]  i_mepc,
    input  logic [W-1:0]  i_mstatus,
    input  logic          i_csr_ready,
    output logic          o_csr_we,
    output logic [11:0]   o_csr_addr,
    output logic [W-1:0]  o_csr_wdata,
    output logic          o_stall_f,
    output logic          o_stall,
    output logic          o_flush_fde,
    output logic          o_redirect_valid,
    output logic [W-1:0]  o_redirect_pc,
    output logic [1:0]    o_current_privilege,
    output logic          o_disable_exceptions_1cc,
    output logic          o_busy
);

    localparam logic [3:0] NoE                  = 4'hF;
    localparam logic [3:0] EFetchAddrMisaligned = 4'd0;
    localparam logic [3:0] EIllegalInstr        = 4'd2;
    localparam logic [3:0] ELoadAddrMisaligned  = 4'd4;
    localparam logic [3:0] ELoadAccessFault     = 4'd5;
    localparam logic [3:0] EStoreAddrMisaligned = 4'd6;
    localparam logic [3:0] EStoreAccessFault    = 4'd7;
    localparam logic [3:0] EEcall               = 4'd8;
    localparam logic [1:0] PrivMachine          = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StWrEpc,
        StWrCause,
        StWrTval,
        StWrStatus,
        StRedirect,
        StMask
    } state_e;

    state_e       state_q, state_d;
    logic [W-1:0] epc_q, epc_d;
    logic [W-1:0] tval_q, tval_d;
    logic [W-1:0] mret_status_q, mret_status_d;
    logic [3:0]   cause_q, cause_d;
    logic         is_mret_q, is_mret_d;
    logic [1:0]   mret_priv_q, mret_priv_d;
    logic [1:0]   priv_q, priv_d;

    logic         e_evt, m_evt, f_pending, f_evt, accept;
    logic [W-1:0] trap_status;
    logic [W-1:0] mret_status;

    assign e_evt     = (i_exc_code_e != NoE);
    assign m_evt     = i_mret_e;
    assign f_pending = (i_exc_code_f != NoE);
    assign f_evt     = f_pending && !i_older_valid_de;
    assign accept    = (state_q == StIdle) && (e_evt || m_evt || f_evt);

    always_comb begin
        trap_status        = i_mstatus;
        trap_status[7]     = i_mstatus[3];
        trap_status[3]     = 1'b0;
        trap_status[12:11] = priv_q;

        mret_status        = i_mstatus;
        mret_status[3]     = i_mstatus[7];
        mret_status[7]     = 1'b1;
        mret_status[12:11] = 2'b00;
    end

    always_comb begin
        state_d       = state_q;
        epc_d         = epc_q;
        tval_d        = tval_q;
        mret_status_d = mret_status_q;
        cause_d       = cause_q;
        is_mret_d     = is_mret_q;
        mret_priv_d   = mret_priv_q;
        priv_d        = priv_q;

        unique case (state_q)
            StIdle: begin
                if (e_evt) begin
                    is_mret_d = 1'b0;
                    epc_d     = i_pc_e;
                    cause_d   = (i_exc_code_e == EEcall) ? 4'd8 + {2'b00, priv_q} : i_exc_code_e;
                    tval_d    = (i_exc_code_e inside {ELoadAddrMisaligned, ELoadAccessFault,
                                                      EStoreAddrMisaligned, EStoreAccessFault})
                                ? i_alu_out_e : '0;
                    state_d   = StWrEpc;
                end else if (m_evt) begin
                    is_mret_d     = 1'b1;
                    epc_d         = i_mepc;
                    mret_priv_d   = i_mstatus[12:11];
                    mret_status_d = mret_status;
                    state_d       = StWrStatus;
                end else if (f_evt) begin
                    is_mret_d = 1'b0;
                    epc_d     = i_pc_f;
                    cause_d   = i_exc_code_f;
                    if (i_exc_code_f == EFetchAddrMisaligned) begin
                        tval_d = i_pc_f;
                    end else if (i_exc_code_f == EIllegalInstr) begin
                        tval_d = {{(W-32){1'b0}}, i_instr_f};
                    end else begin
                        tval_d = '0;
                    end
                    state_d = StWrEpc;
                end
            end
            StWrEpc:    if (i_csr_ready) state_d = StWrCause;
            StWrCause:  if (i_csr_ready) state_d = StWrTval;
            StWrTval:   if (i_csr_ready) state_d = StWrStatus;
            StWrStatus: if (i_csr_ready) state_d = StRedirect;
            StRedirect: begin
                priv_d  = is_mret_q ? mret_priv_q : PrivMachine;
                state_d = StMask;
            end
            StMask:     state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= StIdle;
            epc_q         <= '0;
            tval_q        <= '0;
            mret_status_q <= '0;
            cause_q       <= '0;
            is_mret_q     <= 1'b0;
            mret_priv_q   <= 2'b00;
            priv_q        <= PrivMachine;
        end else begin
            state_q       <= state_d;
            epc_q         <= epc_d;
            tval_q        <= tval_d;
            mret_status_q <= mret_status_d;
            cause_q       <= cause_d;
            is_mret_q     <= is_mret_d;
            mret_priv_q   <= mret_priv_d;
            priv_q        <= priv_d;
        end
    end

    always_comb begin
        o_csr_we                 = 1'b0;
        o_csr_addr               = 12'h000;
        o_csr_wdata              = '0;
        o_stall_f                = 1'b0;
        o_stall                  = 1'b0;
        o_flush_fde              = 1'b0;
        o_redirect_valid         = 1'b0;
        o_redirect_pc            = '0;
        o_disable_exceptions_1cc = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Accept is combinational so the faulting instruction is squashed this cycle
                o_stall     = accept;
                o_flush_fde = accept;
                o_stall_f   = f_pending && i_older_valid_de && !e_evt && !m_evt;
            end
            StWrEpc: begin
                o_csr_we    = 1'b1;
                o_csr_addr  = 12'h341;
                o_csr_wdata = {epc_q[W-1:2], 2'b00};
                o_stall     = 1'b1;
            end
            StWrCause: begin
                o_csr_we    = 1'b1;
                o_csr_addr  = 12'h342;
                o_csr_wdata = {{(W-4){1'b0}}, cause_q};
                o_stall     = 1'b1;
            end
            StWrTval: begin
                o_csr_we    = 1'b1;
                o_csr_addr  = 12'h343;
                o_csr_wdata = tval_q;
                o_stall     = 1'b1;
            end
            StWrStatus: begin
                o_csr_we    = 1'b1;
                o_csr_addr  = 12'h300;
                o_csr_wdata = is_mret_q ? mret_status_q : trap_status;
                o_stall     = 1'b1;
            end
            StRedirect: begin
                o_redirect_valid = 1'b1;
                o_flush_fde      = 1'b1;
                o_stall          = 1'b1;
                o_redirect_pc    = is_mret_q ? epc_q : {i_mtvec[W-1:2], 2'b00};
            end
            StMask:  o_disable_exceptions_1cc = 1'b1;
            default: ;
        endcase
    end

    assign o_busy              = (state_q != StIdle);
    assign o_current_privilege = priv_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: queue-based behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_trap_sequencer;

    localparam logic [3:0] NO_E = 4'hF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  exc_f, exc_e;
    logic [63:0] pc_f, pc_e, alu, mtvec, mepc, mstatus;
    logic [31:0] instr;
    logic        mret, older, ready;

    logic        csr_we, stall_f, stall, flush, rv, dis, busy;
    logic [11:0] csr_addr;
    logic [63:0] csr_wdata, redir_pc;
    logic [1:0]  priv;

    always #5 clk = ~clk;

    trap_sequencer dut (
        .i_clk                    (clk),
        .i_rst_n                  (rst_n),
        .i_exc_code_f             (exc_f),
        .i_exc_code_e             (exc_e),
        .i_pc_f                   (pc_f),
        .i_pc_e                   (pc_e),
        .i_instr_f                (instr),
        .i_alu_out_e              (alu),
        .i_mret_e                 (mret),
        .i_older_valid_de         (older),
        .i_mtvec                  (mtvec),
        .i_mepc                   (mepc),
        .i_mstatus                (mstatus),
        .i_csr_ready              (ready),
        .o_csr_we                 (csr_we),
        .o_csr_addr               (csr_addr),
        .o_csr_wdata              (csr_wdata),
        .o_stall_f                (stall_f),
        .o_stall                  (stall),
        .o_flush_fde              (flush),
        .o_redirect_valid         (rv),
        .o_redirect_pc            (redir_pc),
        .o_current_privilege      (priv),
        .o_disable_exceptions_1cc (dis),
        .o_busy                   (busy)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: pending CSR writes in order, then a redirect, then one mask cycle.
    typedef struct packed {
        logic [11:0] addr;
        logic [63:0] data;
        logic        live_status;
    } wr_t;

    wr_t         wq[$];
    bit          m_redir, m_mask, m_to_mtvec;
    logic [63:0] m_redir_pc;
    logic [1:0]  m_priv, m_new_priv;

    logic [11:0] got_addr[$];
    logic [63:0] got_data[$];
    logic [63:0] last_redir;
    logic        last_we, last_stall, last_stall_f;
    logic [11:0] last_addr;

    function automatic bit model_busy();
        return (wq.size() > 0) || m_redir || m_mask;
    endfunction

    function automatic logic [63:0] trap_status(input logic [63:0] ms, input logic [1:0] p);
        return (ms & ~64'h1888) | (ms[3] ? 64'h80 : 64'h0) | (64'(p) << 11);
    endfunction

    function automatic logic [63:0] mret_status(input logic [63:0] ms);
        return (ms & ~64'h1888) | (ms[7] ? 64'h8 : 64'h0) | 64'h80;
    endfunction

    task automatic model_reset();
        wq.delete();
        m_redir = 0;
        m_mask = 0;
        m_priv = 2'b11;
    endtask

    task automatic push_trap(input logic [63:0] cause, input logic [63:0] epc,
                             input logic [63:0] tval);
        wq.push_back('{12'h341, epc & ~64'h3, 1'b0});
        wq.push_back('{12'h342, cause, 1'b0});
        wq.push_back('{12'h343, tval, 1'b0});
        wq.push_back('{12'h300, 64'h0, 1'b1});
        m_redir = 1;
        m_to_mtvec = 1;
        m_new_priv = 2'b11;
    endtask

    // Called just after a rising edge with inputs set; compares at the falling edge.
    task automatic cycle();
        logic        e_we, e_stall, e_stall_f, e_flush, e_rv, e_dis, e_busy;
        logic [11:0] e_addr;
        logic [63:0] e_data, e_pc, tv;
        bit          ev_e, ev_m, ev_f;
        @(negedge clk);
        e_we = 0; e_stall = 0; e_stall_f = 0; e_flush = 0; e_rv = 0; e_dis = 0; e_busy = 0;
        e_addr = 0; e_data = 0; e_pc = 0;
        ev_e = (exc_e != NO_E);
        ev_m = mret;
        ev_f = (exc_f != NO_E) && !older;
        if (wq.size() > 0) begin
            e_we = 1; e_stall = 1; e_busy = 1;
            e_addr = wq[0].addr;
            e_data = wq[0].live_status ? trap_status(mstatus, m_priv) : wq[0].data;
        end else if (m_redir) begin
            e_rv = 1; e_flush = 1; e_stall = 1; e_busy = 1;
            e_pc = m_to_mtvec ? (mtvec & ~64'h3) : m_redir_pc;
        end else if (m_mask) begin
            e_dis = 1; e_busy = 1;
        end else begin
            e_stall_f = (exc_f != NO_E) && older && !ev_e && !ev_m;
            e_stall = ev_e || ev_m || ev_f;
            e_flush = e_stall;
        end
        chk("csr_we", csr_we, e_we);
        if (e_we) begin
            chk("csr_addr", csr_addr, e_addr);
            chk("csr_wdata", csr_wdata, e_data);
        end
        chk("stall", stall, e_stall);
        chk("stall_f", stall_f, e_stall_f);
        chk("flush_fde", flush, e_flush);
        chk("redirect_valid", rv, e_rv);
        if (e_rv) chk("redirect_pc", redir_pc, e_pc);
        chk("disable_exc", dis, e_dis);
        chk("busy", busy, e_busy);
        chk("privilege", priv, m_priv);

        last_we = csr_we; last_addr = csr_addr; last_stall = stall; last_stall_f = stall_f;
        if (csr_we && ready) begin
            got_addr.push_back(csr_addr);
            got_data.push_back(csr_wdata);
        end
        if (rv) last_redir = redir_pc;

        if (wq.size() > 0) begin
            if (ready) wq.delete(0);
        end else if (m_redir) begin
            m_redir = 0;
            m_priv = m_new_priv;
            m_mask = 1;
        end else if (m_mask) begin
            m_mask = 0;
        end else if (ev_e) begin
            tv = (exc_e >= 4'd4 && exc_e <= 4'd7) ? alu : 64'h0;
            push_trap((exc_e == 4'd8) ? 64'd8 + 64'(m_priv) : 64'(exc_e), pc_e, tv);
        end else if (ev_m) begin
            wq.push_back('{12'h300, mret_status(mstatus), 1'b0});
            m_redir = 1;
            m_to_mtvec = 0;
            m_redir_pc = mepc;
            m_new_priv = mstatus[12:11];
        end else if (ev_f) begin
            tv = (exc_f == 4'd0) ? pc_f : (exc_f == 4'd2) ? {32'h0, instr} : 64'h0;
            push_trap(64'(exc_f), pc_f, tv);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        exc_f = NO_E; exc_e = NO_E; mret = 0; older = 0; ready = 1;
    endtask

    task automatic run_to_idle(input string name);
        for (int k = 0; k < 40 && model_busy(); k++) cycle();
        chk(name, busy, 1'b0);
    endtask

    task automatic check_written(input string name, input int idx, input logic [11:0] a,
                                 input logic [63:0] d);
        if (got_addr.size() > idx) begin
            chk({name, "_addr"}, got_addr[idx], a);
            chk({name, "_data"}, got_data[idx], d);
        end else begin
            chk({name, "_missing"}, got_addr.size(), idx + 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sf, held;
        idle_inputs();
        pc_f = 0; pc_e = 0; alu = 0; instr = 0; mtvec = 64'h8000_0103; mepc = 0; mstatus = 0;
        last_redir = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_priv", priv, 2'b11);
        chk("reset_busy", busy, 0);
        chk("reset_we", csr_we, 0);
        chk("reset_stall", stall, 0);
        rst_n = 1;

        // Illegal instruction held off by older instructions for three cycles
        exc_f = 4'd2; pc_f = 64'h1000; instr = 32'hDEAD_BEEF; older = 1;
        sf = 0;
        repeat (3) begin
            cycle();
            if (last_stall_f) sf++;
        end
        chk("illegal_stall_f_cycles", sf, 3);
        chk("illegal_not_accepted", busy, 0);
        older = 0;
        got_addr.delete(); got_data.delete();
        cycle();
        idle_inputs();
        run_to_idle("illegal_done");
        chk("illegal_writes", got_addr.size(), 4);
        check_written("illegal_epc", 0, 12'h341, 64'h1000);
        check_written("illegal_cause", 1, 12'h342, 64'd2);
        check_written("illegal_tval", 2, 12'h343, 64'hDEAD_BEEF);
        chk("illegal_redirect", last_redir, 64'h8000_0100);

        // Same-cycle F and E events: E wins
        exc_f = 4'd2; exc_e = 4'd5; alu = 64'h2003; pc_e = 64'h3000; pc_f = 64'h9000;
        got_addr.delete(); got_data.delete();
        cycle();
        idle_inputs();
        run_to_idle("simul_done");
        check_written("simul_epc", 0, 12'h341, 64'h3000);
        check_written("simul_cause", 1, 12'h342, 64'd5);
        check_written("simul_tval", 2, 12'h343, 64'h2003);

        // MRET back to U-mode
        mstatus = 64'h80; mepc = 64'h400; mret = 1;
        got_addr.delete(); got_data.delete();
        cycle();
        idle_inputs();
        run_to_idle("mret_done");
        chk("mret_writes", got_addr.size(), 1);
        check_written("mret_status", 0, 12'h300, 64'h88);
        chk("mret_redirect", last_redir, 64'h400);
        chk("mret_priv", priv, 2'b00);

        // ECALL from U-mode
        exc_e = 4'd8; pc_e = 64'h500; mstatus = 64'h8;
        got_addr.delete(); got_data.delete();
        cycle();
        idle_inputs();
        run_to_idle("ecall_done");
        check_written("ecall_cause", 1, 12'h342, 64'd8);
        check_written("ecall_tval", 2, 12'h343, 64'd0);
        check_written("ecall_status", 3, 12'h300, 64'h80);
        chk("ecall_priv", priv, 2'b11);

        // CSR backpressure on the mcause write
        exc_e = 4'd4; pc_e = 64'h600; alu = 64'h601;
        cycle();
        idle_inputs();
        cycle();
        ready = 0;
        held = 0;
        repeat (4) begin
            cycle();
            if (last_we && last_addr == 12'h342 && last_stall) held++;
        end
        chk("bp_held_cycles", held, 4);
        chk("bp_still_cause", csr_addr, 12'h342);
        ready = 1;
        run_to_idle("bp_done");

        // Reset in the middle of the mtval write
        exc_e = 4'd6; pc_e = 64'h700; alu = 64'h7FF;
        cycle();
        idle_inputs();
        cycle();
        cycle();
        ready = 0;
        @(negedge clk);
        chk("rst_pre_tval_addr", csr_addr, 12'h343);
        rst_n = 0;
        #1;
        chk("rst_we", csr_we, 0);
        chk("rst_addr", csr_addr, 0);
        chk("rst_wdata", csr_wdata, 0);
        chk("rst_stall", stall, 0);
        chk("rst_stall_f", stall_f, 0);
        chk("rst_flush", flush, 0);
        chk("rst_rv", rv, 0);
        chk("rst_dis", dis, 0);
        chk("rst_busy", busy, 0);
        chk("rst_priv", priv, 2'b11);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        ready = 1;
        exc_e = 4'd7; pc_e = 64'h800;
        got_addr.delete(); got_data.delete();
        cycle();
        idle_inputs();
        run_to_idle("rst_restart_done");
        chk("rst_restart_writes", got_addr.size(), 4);
        check_written("rst_restart_epc", 0, 12'h341, 64'h800);

        // Randomized traffic against the model
        for (int i = 0; i < 2500; i++) begin
            exc_e = ($urandom_range(0, 9) < 7) ? NO_E : 4'(3 + $urandom_range(0, 5));
            exc_f = ($urandom_range(0, 9) < 6) ? NO_E : 4'($urandom_range(0, 2));
            mret = ($urandom_range(0, 19) == 0);
            older = $urandom_range(0, 1) == 1;
            ready = $urandom_range(0, 3) != 0;
            pc_f = {$urandom, $urandom};
            pc_e = {$urandom, $urandom};
            alu = {$urandom, $urandom};
            instr = $urandom;
            mtvec = {$urandom, $urandom};
            mepc = {$urandom, $urandom};
            mstatus = {$urandom, $urandom};
            cycle();
        end
        idle_inputs();
        run_to_idle("random_done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
